// File: rtl/int_to_float_pkg.sv
// Shared float32 field widths, packed layout and constants for the
// integer-code to float32 decoder.
package int_to_float_pkg;

  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_MANT_W   = 23;
  localparam int FP32_EXP_W    = 8;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_MANT_W-1:0] mant;
  } float32_t;

  localparam float32_t FP32_ZERO = '0;

endpackage

// File: rtl/int_to_float_decoder_leading_one_detector.sv
// Combinational leading-one finder: index of the highest set bit, plus a
// flag for an all-zero input (index reads 0 in that case).
module leading_one_detector #(
  parameter int W  = 8,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  value,
  output logic [IW-1:0] index,
  output logic          zero
);

  always_comb begin
    index = '0;
    for (int i = 0; i < W; i++) begin
      if (value[i]) index = IW'(i);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/int_to_float_decoder.sv
// Pipelined integer-code to float32 converter (round-to-nearest-even) with a
// valid/ready stream on both sides; the whole pipe stalls as one.
module int_to_float_decoder
  import int_to_float_pkg::*;
#(
  parameter int CODE_WIDTH = 8,
  parameter int OFFSET     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_WIDTH-1:0] in_code,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_value,
  output logic                  out_inexact
);

  localparam int SW = ((CODE_WIDTH > 16) ? CODE_WIDTH : 16) + 2;
  localparam int IW = $clog2(SW);
  localparam int NW = SW + FP32_MANT_W + 1;

  logic enable;

  logic                  cap_valid;
  logic [CODE_WIDTH-1:0] cap_code;
  logic                  cap_signed;

  logic          s1_valid;
  logic          s1_sign;
  logic [SW-1:0] s1_mag;

  logic          s2_valid;
  logic          s2_sign;
  logic [SW-1:0] s2_mag;
  logic [IW-1:0] s2_p;
  logic          s2_zero;

  float32_t out_reg;

  assign enable    = !out_valid || out_ready;
  assign in_ready  = enable;
  assign out_value = out_reg;

  // S1: the code is registered first so the extend/add path starts from a flop
  logic [SW-1:0] ext;
  logic [SW-1:0] sum;
  logic [SW-1:0] mag;

  assign ext = {{(SW-CODE_WIDTH){cap_signed & cap_code[CODE_WIDTH-1]}}, cap_code};
  assign sum = ext + SW'(OFFSET);
  assign mag = sum[SW-1] ? -sum : sum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid  <= 1'b0;
      cap_code   <= '0;
      cap_signed <= 1'b0;
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_mag     <= '0;
    end else if (enable) begin
      cap_valid  <= in_valid;
      cap_code   <= in_code;
      cap_signed <= in_signed;
      s1_valid   <= cap_valid;
      s1_sign    <= sum[SW-1];
      s1_mag     <= mag;
    end
  end

  // S2: locate the leading one
  logic [IW-1:0] lod_index;
  logic          lod_zero;

  leading_one_detector #(.W(SW), .IW(IW)) u_lod (
    .value (s1_mag),
    .index (lod_index),
    .zero  (lod_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
      s2_p     <= '0;
      s2_zero  <= 1'b1;
    end else if (enable) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_mag   <= s1_mag;
      s2_p     <= lod_index;
      s2_zero  <= lod_zero;
    end
  end

  // S3: shift the implicit one just past the top so the mantissa is left-aligned
  logic [IW:0]            shamt;
  logic [NW-1:0]          norm;
  logic [FP32_MANT_W-1:0] mant;
  logic [FP32_MANT_W-1:0] mant_r;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic                   carry;
  float32_t               result;
  logic                   result_inexact;

  assign shamt  = (IW+1)'(SW) - (IW+1)'(s2_p);
  assign norm   = {s2_mag, {(NW-SW){1'b0}}} << shamt;
  assign mant   = norm[NW-1 -: FP32_MANT_W];
  assign guard  = norm[NW-FP32_MANT_W-1];
  assign sticky = |norm[NW-FP32_MANT_W-2:0];

  always_comb begin
    round_up       = guard & (sticky | mant[0]);
    {carry, mant_r} = {1'b0, mant} + (FP32_MANT_W+1)'(round_up);
    result         = FP32_ZERO;
    result_inexact = 1'b0;
    if (!s2_zero) begin
      result.sign    = s2_sign;
      result.exp     = FP32_EXP_W'(FP32_EXP_BIAS) + FP32_EXP_W'(s2_p) + FP32_EXP_W'(carry);
      result.mant    = mant_r;
      result_inexact = guard | sticky;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_reg     <= FP32_ZERO;
      out_inexact <= 1'b0;
    end else if (enable) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_reg     <= result;
        out_inexact <= result_inexact;
      end
    end
  end

endmodule
